bus_rr_arbiter: RTL and testbench
=================================

// Module: bus_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing the system bus among NUM_REQ bus masters (JTAG DMA, CPU, others).
//  Accepts per-master request lines and drives a one-hot grant that is held for one full bus
//  transaction (begin_transaction .. end_transaction).
//  Watchdogs revoke a grant that is never used or a transaction that never ends, so a hung
//  master (e.g. JTAG DMA after cable loss) cannot lock the bus.
// PARAMETERS
//  NUM_REQ         4     number of requesting masters (2..16)
//  START_TIMEOUT   16    max cycles a grant may sit unused before revocation; 0 = disabled
//  ACTIVE_TIMEOUT  4096  max cycles from begin_transaction to end_transaction; 0 = disabled
// PORTS
//  clock                in   1                system clock, all logic on rising edge
//  reset                in   1                synchronous, active-high
//  request              in   NUM_REQ          request[i] high = master i wants the bus
//  grant                out  NUM_REQ          one-hot grant, registered
//  grant_valid          out  1                OR of grant
//  grant_id             out  $clog2(NUM_REQ)  index of granted master (valid when grant_valid)
//  begin_transactionIN  in   1                bus begin_transaction (OR of all masters)
//  end_transactionIN    in   1                bus end_transaction (slave or master driven)
//  timeout_pulse        out  1                1-cycle pulse when any watchdog revokes a grant
// BEHAVIOUR
//  Reset: grant=0, grant_valid=0, grant_id=0, timeout_pulse=0, state=IDLE, wdog counter=0,
//   last_winner=NUM_REQ-1 (master 0 has priority after reset). Reset mid-transaction drops
//   grant on the next edge; no end_transaction is awaited.
//  States:
//   IDLE    : grant=0. If |request: winner = first set request[k], k scanned from
//             last_winner+1 upward with wrap-around; next state GRANTED, grant[winner]=1,
//             grant_id=winner, last_winner=winner, counter=0. Else stay.
//   GRANTED : wait for master to start. Priority, highest first:
//             begin_transactionIN & end_transactionIN -> RELEASE (single-cycle transaction);
//             begin_transactionIN -> ACTIVE, counter=0;
//             request[grant_id]==0 -> RELEASE (withdrawn, no timeout_pulse);
//             START_TIMEOUT!=0 & counter==START_TIMEOUT-1 -> RELEASE, timeout_pulse=1;
//             else counter+1.
//   ACTIVE  : request level ignored; grant held until end.
//             end_transactionIN -> RELEASE;
//             ACTIVE_TIMEOUT!=0 & counter==ACTIVE_TIMEOUT-1 -> RELEASE, timeout_pulse=1;
//             else counter+1.
//   RELEASE : grant=0 for exactly one cycle (bus turnaround), then IDLE.
//  Latency: request high in IDLE at cycle n -> grant visible cycle n+1.
//   end_transactionIN at cycle m -> grant low at m+1 (RELEASE), IDLE at m+2, next grant
//   visible at m+3 at the earliest.
//  grant, grant_valid and grant_id change only on state entry. grant is never multi-hot.
//   grant is 0 in IDLE and RELEASE.
//  Counter width $clog2(max(START_TIMEOUT,ACTIVE_TIMEOUT)+1). Counter saturates; it never wraps.
//  begin_transactionIN or end_transactionIN seen in IDLE/RELEASE: ignored (no state change).
//  timeout_pulse is registered; it is high in the first RELEASE cycle only.
//  Fairness: every continuously requesting master is granted within NUM_REQ grants.
// TESTING
//  1 Only request[2] rises at cycle 0 -> grant=4'b0100, grant_id=2 at cycle 1;
//    begin at 3, end at 10 -> grant=0 at 11, at 12 still 0.
//  2 request=4'b1111 held; each master does begin then end 2 cycles later
//    -> grant order 0,1,2,3,0; 1 idle and 1 release cycle between grants.
//  3 request[1] only, no begin for 16 cycles -> grant drops at cycle 17, timeout_pulse=1
//    for 1 cycle; re-grant to 1 at cycle 19.
//  4 request[3] withdrawn in GRANTED -> release, no pulse; withdrawn in ACTIVE
//    -> grant kept until end_transactionIN.
//  5 reset asserted mid-ACTIVE with request=4'b1010 -> grant=0 next edge;
//    after reset release -> master 1 granted first.
//  6 ACTIVE_TIMEOUT=0, transaction 10000 cycles long -> grant held throughout,
//    timeout_pulse never asserted.

Source files
------------

// File: rtl/bus_rr_arbiter_if.sv
// Bus arbitration interface: request/grant lines plus the shared
// begin/end transaction strobes and the watchdog revocation pulse.
interface bus_rr_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] request;
  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_id;
  logic               begin_transactionIN;
  logic               end_transactionIN;
  logic               timeout_pulse;

  // Bus-master side: raises requests and drives the transaction strobes.
  modport master (
    output request,
    output begin_transactionIN,
    output end_transactionIN,
    input  grant,
    input  grant_valid,
    input  grant_id,
    input  timeout_pulse
  );

  // Arbiter side: observes requests and strobes, drives the grant.
  modport slave (
    input  request,
    input  begin_transactionIN,
    input  end_transactionIN,
    output grant,
    output grant_valid,
    output grant_id,
    output timeout_pulse
  );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter. A one-hot grant is held for a whole bus
// transaction; start and active watchdogs revoke the grant from a hung
// master, and a one-cycle RELEASE state gives bus turnaround between owners.
module bus_rr_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int START_TIMEOUT  = 16,
  parameter int ACTIVE_TIMEOUT = 4096
) (
  input  logic             clock,
  input  logic             reset,
  bus_rr_arbiter_if.slave  bus
);

  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX   = (START_TIMEOUT > ACTIVE_TIMEOUT) ? START_TIMEOUT : ACTIVE_TIMEOUT;
  localparam int CNT_W     = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam int ST_LAST   = (START_TIMEOUT > 0) ? START_TIMEOUT - 1 : 0;
  localparam int AT_LAST   = (ACTIVE_TIMEOUT > 0) ? ACTIVE_TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [ID_W-1:0]    last_winner_q, last_winner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;

  logic               found;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    idx;
  logic               req_granted;
  logic               st_expired;
  logic               at_expired;

  // Watchdog counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign req_granted = bus.request[grant_id_q];
  assign st_expired  = (START_TIMEOUT != 0)  && (cnt_q == CNT_W'(ST_LAST));
  assign at_expired  = (ACTIVE_TIMEOUT != 0) && (cnt_q == CNT_W'(AT_LAST));

  // Round-robin search: first active request after the last winner, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((int'(last_winner_q) + i) % NUM_REQ);
      if (!found && bus.request[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // State register and registered outputs; reset drops any grant immediately.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_id_q    <= '0;
      last_winner_q <= ID_W'(NUM_REQ - 1);
      cnt_q         <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      last_winner_q <= last_winner_d;
      cnt_q         <= cnt_d;
      timeout_q     <= timeout_d;
    end
  end

  // Next-state logic; a watchdog-forced release also flags the timeout pulse.
  always_comb begin
    state_d   = state_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) state_d = GRANTED;
      end
      GRANTED: begin
        if (bus.begin_transactionIN && bus.end_transactionIN) begin
          state_d = RELEASE;
        end else if (bus.begin_transactionIN) begin
          state_d = ACTIVE;
        end else if (!req_granted) begin
          state_d = RELEASE;
        end else if (st_expired) begin
          state_d   = RELEASE;
          timeout_d = 1'b1;
        end
      end
      ACTIVE: begin
        if (bus.end_transactionIN) begin
          state_d = RELEASE;
        end else if (at_expired) begin
          state_d   = RELEASE;
          timeout_d = 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next grant, id, winner and counter values, changing only on state entry.
  always_comb begin
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    last_winner_d = last_winner_q;
    cnt_d         = cnt_q;
    if (state_q == IDLE && state_d == GRANTED) begin
      grant_d       = NUM_REQ'(1) << winner;
      grant_id_d    = winner;
      last_winner_d = winner;
      cnt_d         = '0;
    end else if (state_q == GRANTED && state_d == ACTIVE) begin
      cnt_d = '0;
    end else if (state_d == RELEASE || state_d == IDLE) begin
      grant_d = '0;
      cnt_d   = '0;
    end else begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  assign bus.grant         = grant_q;
  assign bus.grant_valid   = |grant_q;
  assign bus.grant_id      = grant_id_q;
  assign bus.timeout_pulse = timeout_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed scoreboard bench for bus_rr_arbiter: stimulus pushes expected
// grant/release events (vector, id, cycle, pulse); a negedge monitor pops
// and compares them whenever the grant changes.
module tb_bus_rr_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_rr_arbiter_if #(.NUM_REQ(N)) bus ();
  bus_rr_arbiter_if #(.NUM_REQ(N)) bus_nt ();

  bus_rr_arbiter #(.NUM_REQ(N), .START_TIMEOUT(16), .ACTIVE_TIMEOUT(4096)) u_dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  bus_rr_arbiter #(.NUM_REQ(N), .START_TIMEOUT(16), .ACTIVE_TIMEOUT(0)) u_dut_nt (
    .clock (clk),
    .reset (reset),
    .bus   (bus_nt)
  );

  typedef struct {
    logic [N-1:0] vec;
    int           id;
    int           cyc;
  } gexp_t;

  typedef struct {
    int   cyc;
    logic pulse;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic at(input int abs_cyc);
    if (cyc > abs_cyc) check("sched_late", cyc, abs_cyc);
    while (cyc < abs_cyc) tick(1);
  endtask

  task automatic push_g(input logic [N-1:0] vec, input int id, input int c);
    gexp_t e;
    e.vec = vec; e.id = id; e.cyc = c;
    gq.push_back(e);
  endtask

  task automatic push_r(input int c, input logic pulse);
    rexp_t e;
    e.cyc = c; e.pulse = pulse;
    rq.push_back(e);
  endtask

  // Monitor: every grant change is either a new grant or a release.
  logic [N-1:0] prev_grant = '0;
  always @(negedge clk) begin
    if (bus.grant !== prev_grant) begin
      if (bus.grant != '0) begin
        if (gq.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_grant: got %b expected none (cycle %0d)", bus.grant, cyc);
        end else begin
          gexp_t g;
          g = gq.pop_front();
          check("grant_vec", bus.grant, g.vec);
          check("grant_id", bus.grant_id, g.id);
          check("grant_cyc", cyc, g.cyc);
          check("grant_valid", bus.grant_valid, 1);
        end
      end else begin
        if (rq.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_release: got grant 0 expected %b held (cycle %0d)", prev_grant, cyc);
        end else begin
          rexp_t r;
          r = rq.pop_front();
          check("release_cyc", cyc, r.cyc);
          check("release_pulse", bus.timeout_pulse, r.pulse);
          check("release_valid", bus.grant_valid, 0);
        end
      end
    end else if (bus.timeout_pulse) begin
      errors++; checks++;
      $display("FAIL spurious_pulse: got 1 expected 0 (cycle %0d)", cyc);
    end
    if (!$onehot0(bus.grant)) begin
      errors++; checks++;
      $display("FAIL multi_hot: got %b expected one-hot (cycle %0d)", bus.grant, cyc);
    end
    prev_grant = bus.grant;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 40000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int held_bad;
    bus.request = '0;
    bus.begin_transactionIN = 1'b0;
    bus.end_transactionIN = 1'b0;
    bus_nt.request = '0;
    bus_nt.begin_transactionIN = 1'b0;
    bus_nt.end_transactionIN = 1'b0;
    reset = 1'b1;
    tick(3);

    // Reset state
    check("rst_grant", bus.grant, 0);
    check("rst_valid", bus.grant_valid, 0);
    check("rst_id", bus.grant_id, 0);
    check("rst_pulse", bus.timeout_pulse, 0);
    check("rst_nt_grant", bus_nt.grant, 0);
    reset = 1'b0;
    tick(1);

    // 1: single requester, begin at +3, end at +10
    c = cyc;
    bus.request = 4'b0100;
    push_g(4'b0100, 2, c + 1);
    at(c + 3);
    bus.begin_transactionIN = 1'b1; tick(1); bus.begin_transactionIN = 1'b0;
    at(c + 10);
    bus.end_transactionIN = 1'b1; bus.request = '0;
    push_r(c + 11, 1'b0);
    tick(1); bus.end_transactionIN = 1'b0;
    at(c + 12);
    check("t1_idle_grant", bus.grant, 0);

    // 2: all request after reset -> order 0,1,2,3,0 with 5-cycle spacing
    reset = 1'b1; tick(1); reset = 1'b0; tick(1);
    c = cyc;
    bus.request = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      push_g(4'b0001 << (k % 4), k % 4, c + 1 + 5 * k);
      push_r(c + 4 + 5 * k, 1'b0);
    end
    for (int k = 0; k < 5; k++) begin
      at(c + 1 + 5 * k);
      bus.begin_transactionIN = 1'b1; tick(1); bus.begin_transactionIN = 1'b0;
      at(c + 3 + 5 * k);
      bus.end_transactionIN = 1'b1;
      if (k == 4) bus.request = '0;
      tick(1); bus.end_transactionIN = 1'b0;
    end

    // 3: start watchdog revokes an unused grant, then re-grant
    tick(2);
    c = cyc;
    bus.request = 4'b0010;
    push_g(4'b0010, 1, c + 1);
    push_r(c + 17, 1'b1);
    push_g(4'b0010, 1, c + 19);
    at(c + 19);
    bus.request = '0;
    push_r(c + 20, 1'b0);
    tick(1);

    // 4a: withdrawal in GRANTED releases without a pulse
    tick(2);
    c = cyc;
    bus.request = 4'b1000;
    push_g(4'b1000, 3, c + 1);
    at(c + 2);
    bus.request = '0;
    push_r(c + 3, 1'b0);
    // 4b: withdrawal in ACTIVE keeps the grant until end
    at(c + 4);
    c = cyc;
    bus.request = 4'b1000;
    push_g(4'b1000, 3, c + 1);
    at(c + 1);
    bus.begin_transactionIN = 1'b1; tick(1); bus.begin_transactionIN = 1'b0;
    bus.request = '0;
    at(c + 8);
    bus.end_transactionIN = 1'b1;
    push_r(c + 9, 1'b0);
    tick(1); bus.end_transactionIN = 1'b0;

    // 5: reset mid-ACTIVE drops grant; master 1 wins first afterwards
    tick(2);
    c = cyc;
    bus.request = 4'b1010;
    push_g(4'b0010, 1, c + 1);
    at(c + 1);
    bus.begin_transactionIN = 1'b1; tick(1); bus.begin_transactionIN = 1'b0;
    at(c + 4);
    reset = 1'b1;
    push_r(c + 5, 1'b0);
    tick(1);
    check("t5_rst_id", bus.grant_id, 0);
    check("t5_rst_pulse", bus.timeout_pulse, 0);
    tick(1);
    reset = 1'b0;
    push_g(4'b0010, 1, c + 7);
    at(c + 7);
    bus.request = '0;
    push_r(c + 8, 1'b0);
    tick(1);

    // Active watchdog: begin but never end -> revoke after 4096 cycles
    tick(2);
    c = cyc;
    bus.request = 4'b0001;
    push_g(4'b0001, 0, c + 1);
    at(c + 1);
    bus.begin_transactionIN = 1'b1; tick(1); bus.begin_transactionIN = 1'b0;
    bus.request = '0;
    push_r(c + 4098, 1'b1);
    at(c + 4099);

    // 6: active watchdog disabled, 10000-cycle transaction held throughout
    c = cyc;
    held_bad = 0;
    bus_nt.request = 4'b0001;
    at(c + 1);
    check("t6_grant", bus_nt.grant, 4'b0001);
    bus_nt.begin_transactionIN = 1'b1; tick(1); bus_nt.begin_transactionIN = 1'b0;
    while (cyc < c + 10001) begin
      if (bus_nt.grant != 4'b0001 || bus_nt.timeout_pulse) held_bad++;
      tick(1);
    end
    check("t6_held_bad_cycles", held_bad, 0);
    check("t6_grant_at_end", bus_nt.grant, 4'b0001);
    bus_nt.end_transactionIN = 1'b1; bus_nt.request = '0;
    tick(1); bus_nt.end_transactionIN = 1'b0;
    check("t6_release_grant", bus_nt.grant, 0);
    check("t6_release_pulse", bus_nt.timeout_pulse, 0);

    tick(5);
    check("grant_events_left", gq.size(), 0);
    check("release_events_left", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
